// File: rtl/xgriscv_fetch.sv
// xgriscv instruction fetch: fetch PC, imem addressing and {pc, inst} queue.
// Define FETCH_MISALIGN_CHK_EN to halt fetch on a misaligned redirect target.
module xgriscv_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          IMEM_AW  = 8,
  parameter int          DEPTH    = 2
) (
  input  logic               clk,
  input  logic               rstn,
  output logic [IMEM_AW-1:0] imem_addr,
  input  logic [31:0]        imem_rdata,
  input  logic               redirect_valid,
  input  logic [31:0]        redirect_pc,
  output logic               inst_valid,
  input  logic               inst_ready,
  output logic [31:0]        inst,
  output logic [31:0]        inst_pc
`ifdef FETCH_MISALIGN_CHK_EN
  ,
  output logic               misalign
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic [31:0]   fpc;
  logic [31:0]   q_pc   [DEPTH];
  logic [31:0]   q_word [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] count;
  logic          halted;
  logic          pop;
  logic          push;
  logic          redir;

`ifdef FETCH_MISALIGN_CHK_EN
  logic bad_target;
  assign bad_target = |redirect_pc[1:0];
`else
  assign halted = 1'b0;
`endif

  assign imem_addr  = fpc[IMEM_AW+1:2];
  assign inst_valid = (count != '0);
  assign inst       = q_word[rd_ptr];
  assign inst_pc    = q_pc[rd_ptr];

  assign pop   = inst_valid & inst_ready;
  assign redir = redirect_valid & !halted;
  assign push  = !redirect_valid & !halted
               & ((count < FULL) | pop);

  always_ff @(posedge clk) begin
    if (rstn) begin
      fpc    <= RESET_PC;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        q_pc[i]   <= 32'h0;
        q_word[i] <= NOP;
      end
`ifdef FETCH_MISALIGN_CHK_EN
      halted   <= 1'b0;
      misalign <= 1'b0;
`endif
    end else if (redir) begin
      // flush: a concurrent pop is consumed downstream but not re-counted
      count  <= '0;
      rd_ptr <= wr_ptr;
      fpc    <= {redirect_pc[31:2], 2'b00};
`ifdef FETCH_MISALIGN_CHK_EN
      if (bad_target) begin
        halted   <= 1'b1;
        misalign <= 1'b1;
      end
`endif
    end else begin
      if (push) begin
        q_pc[wr_ptr]   <= fpc;
        q_word[wr_ptr] <= imem_rdata;
        wr_ptr         <= wr_ptr + 1'b1;
        fpc            <= fpc + 32'd4;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (push && !pop) begin
        count <= count + 1'b1;
      end else if (pop && !push) begin
        count <= count - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_xgriscv_fetch.sv
// Directed bench for xgriscv_fetch: vector table plus redirect/misalign sequences.
// Honours FETCH_MISALIGN_CHK_EN to exercise the misalign flag.
module tb_xgriscv_fetch;

  logic        clk;
  logic        rstn;
  logic [7:0]  imem_addr;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
`ifdef FETCH_MISALIGN_CHK_EN
  logic        misalign;
`endif

  logic [31:0] mem [256];
  int checks = 0;
  int errors = 0;

  assign imem_rdata = mem[imem_addr];

  xgriscv_fetch #(
    .RESET_PC(32'h0),
    .IMEM_AW (8),
    .DEPTH   (2)
  ) dut (
    .clk           (clk),
    .rstn          (rstn),
    .imem_addr     (imem_addr),
    .imem_rdata    (imem_rdata),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .inst_valid    (inst_valid),
    .inst_ready    (inst_ready),
    .inst          (inst),
    .inst_pc       (inst_pc)
`ifdef FETCH_MISALIGN_CHK_EN
    ,
    .misalign      (misalign)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        rv;
    logic [31:0] rpc;
    logic        rdy;
    logic        ev;
    logic        dchk;
    logic [31:0] ei;
    logic [31:0] ep;
    logic [7:0]  ea;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step(input logic rst, input logic rv,
                      input logic [31:0] rpc, input logic rdy);
    rstn           = rst;
    redirect_valid = rv;
    redirect_pc    = rpc;
    inst_ready     = rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic rst, input logic rv,
                     input logic [31:0] rpc, input logic rdy,
                     input logic ev, input logic dchk,
                     input logic [31:0] ei, input logic [31:0] ep,
                     input logic [7:0] ea);
    vec_t v;
    v.rst = rst; v.rv = rv; v.rpc = rpc; v.rdy = rdy;
    v.ev = ev; v.dchk = dchk; v.ei = ei; v.ep = ep; v.ea = ea;
    tbl.push_back(v);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'hA000_0000 + i;
    mem[0] = 32'h0000_0293;
    mem[1] = 32'h0000_0313;
    mem[2] = 32'hFFFF_F3B7;
    mem[3] = 32'h0000_0013;

    rstn = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc = 32'h0;
    inst_ready = 1'b0;

    // reset release, streaming
    add(1, 0, 0, 1, 0, 1, 32'h13, 32'h0, 8'h00);
    add(0, 0, 0, 1, 1, 1, 32'h293, 32'h0, 8'h01);
    add(0, 0, 0, 1, 1, 1, 32'h313, 32'h4, 8'h02);
    add(0, 0, 0, 1, 1, 1, 32'hFFFF_F3B7, 32'h8, 8'h03);
    add(0, 0, 0, 1, 1, 1, 32'h13, 32'hC, 8'h04);
    // back-pressure for 5 cycles, then drain
    add(1, 0, 0, 0, 0, 1, 32'h13, 32'h0, 8'h00);
    add(0, 0, 0, 0, 1, 1, 32'h293, 32'h0, 8'h01);
    add(0, 0, 0, 0, 1, 1, 32'h293, 32'h0, 8'h02);
    add(0, 0, 0, 0, 1, 1, 32'h293, 32'h0, 8'h02);
    add(0, 0, 0, 0, 1, 1, 32'h293, 32'h0, 8'h02);
    add(0, 0, 0, 0, 1, 1, 32'h293, 32'h0, 8'h02);
    add(0, 0, 0, 1, 1, 1, 32'h313, 32'h4, 8'h03);
    add(0, 0, 0, 1, 1, 1, 32'hFFFF_F3B7, 32'h8, 8'h04);
    add(0, 0, 0, 1, 1, 1, 32'h13, 32'hC, 8'h05);
    // redirect while full
    add(0, 0, 0, 0, 1, 1, 32'h13, 32'hC, 8'h05);
    add(0, 1, 32'h174, 0, 0, 0, 0, 0, 8'h5D);
    add(0, 0, 0, 0, 1, 1, 32'hA000_005D, 32'h174, 8'h5E);
    add(0, 0, 0, 0, 1, 1, 32'hA000_005D, 32'h174, 8'h5F);
    // redirect with pop, then redirect over a push attempt
    add(0, 1, 32'h200, 1, 0, 0, 0, 0, 8'h80);
    add(0, 0, 0, 1, 1, 1, 32'hA000_0080, 32'h200, 8'h81);
    add(0, 1, 32'h3FC, 0, 0, 0, 0, 0, 8'hFF);
    add(0, 0, 0, 1, 1, 1, 32'hA000_00FF, 32'h3FC, 8'h00);
    add(0, 0, 0, 1, 1, 1, 32'h293, 32'h400, 8'h01);
    // 32-bit fpc wrap
    add(0, 1, 32'hFFFF_FFFC, 1, 0, 0, 0, 0, 8'hFF);
    add(0, 0, 0, 1, 1, 1, 32'hA000_00FF, 32'hFFFF_FFFC, 8'h00);
    add(0, 0, 0, 1, 1, 1, 32'h293, 32'h0, 8'h01);

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].rst, tbl[i].rv, tbl[i].rpc, tbl[i].rdy);
      chk($sformatf("row%0d_valid", i), {31'h0, inst_valid},
          {31'h0, tbl[i].ev});
      chk($sformatf("row%0d_addr", i), {24'h0, imem_addr},
          {24'h0, tbl[i].ea});
      if (tbl[i].dchk) begin
        chk($sformatf("row%0d_inst", i), inst, tbl[i].ei);
        chk($sformatf("row%0d_pc", i), inst_pc, tbl[i].ep);
      end
    end

`ifdef FETCH_MISALIGN_CHK_EN
    step(0, 0, 0, 1);
    chk("mis_pre", {31'h0, misalign}, 32'h0);
    step(0, 1, 32'h102, 1);
    chk("mis_set", {31'h0, misalign}, 32'h1);
    chk("mis_valid0", {31'h0, inst_valid}, 32'h0);
    for (int i = 0; i < 10; i++) begin
      step(0, (i == 3), 32'h100, 1);
      chk($sformatf("mis_hold%0d_valid", i), {31'h0, inst_valid}, 32'h0);
      chk($sformatf("mis_hold%0d_flag", i), {31'h0, misalign}, 32'h1);
    end
    step(1, 0, 0, 1);
    chk("mis_rst_flag", {31'h0, misalign}, 32'h0);
    chk("mis_rst_valid", {31'h0, inst_valid}, 32'h0);
    step(0, 0, 0, 1);
    chk("mis_restart_valid", {31'h0, inst_valid}, 32'h1);
    chk("mis_restart_pc", inst_pc, 32'h0);
    chk("mis_restart_inst", inst, 32'h293);
`else
    step(0, 1, 32'h102, 1);
    chk("unal_valid0", {31'h0, inst_valid}, 32'h0);
    chk("unal_addr", {24'h0, imem_addr}, 32'h40);
    step(0, 0, 0, 1);
    chk("unal_valid1", {31'h0, inst_valid}, 32'h1);
    chk("unal_pc", inst_pc, 32'h100);
    chk("unal_inst", inst, 32'hA000_0040);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/xgriscv_fetch.md
# xgriscv_fetch

Instruction-fetch front end for the xgriscv core, sitting directly upstream of decode/execute. Holds the fetch PC, drives the word address of the asynchronous-read instruction memory (U_imem), and buffers fetched {pc, instruction} pairs in a small FIFO. The FIFO feeds the downstream stage through a valid/ready handshake. Taken branches and jumps from downstream arrive as a redirect, which flushes the buffer and restarts fetch at the target.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, fetch PC loaded on reset
- IMEM_AW, 8, instruction-memory word-address width (256 words)
- DEPTH, 2, fetch-queue entries; power of two, at least 2

Ports:
- clk  in  1  single clock; all state changes on the rising edge
- rstn  in  1  synchronous, active-high reset: sampled on the rising edge of clk, and a 1 resets the block
- imem_addr  out  IMEM_AW  word address to imem, equal to fpc[IMEM_AW+1:2] (combinational from the fpc register)
- imem_rdata  in  32  instruction word at imem_addr, same-cycle (asynchronous read)
- redirect_valid  in  1  downstream requests a PC change this cycle
- redirect_pc  in  32  redirect target byte address
- inst_valid  out  1  queue head holds a valid instruction
- inst_ready  in  1  downstream accepts the head this cycle
- inst  out  32  head instruction word
- inst_pc  out  32  byte address of the head instruction
- misalign  out  1  sticky misaligned-redirect flag; present only with the configuration macro

## Operation
- State:
  - fpc register (32 bits)
  - queue of DEPTH entries {pc[31:0], word[31:0]}
  - rd_ptr and wr_ptr (log2 DEPTH bits each)
  - count (0..DEPTH)
  - halted bit (macro only)
- pop = inst_valid & inst_ready. A pop removes the head.
- push = !redirect_valid & !halted & (count < DEPTH | pop).
  - The entry written is {fpc, imem_rdata}.
  - fpc advances by 4 on a push.
- Push and pop in the same cycle when full is legal: count stays at DEPTH.
- Redirect (highest priority):
  - count ← 0, rd_ptr ← wr_ptr, fpc ← redirect_pc.
  - No push occurs in that cycle.
  - A simultaneous pop is accepted by the consumer, but has no effect on the queue.
- fpc wraps modulo 2^32: 32'hFFFF_FFFC + 4 = 0.
- imem_addr uses only fpc[IMEM_AW+1:2], so fetch wraps around the imem size.
- inst_valid = (count != 0).
- inst and inst_pc come from the registered head entry. They are stable while inst_valid=1 and inst_ready=0.

## Timing
- Reset values:
  - fpc = RESET_PC, count = 0, pointers = 0
  - all queue entries = {32'h0, 32'h0000_0013} (nop)
  - inst_valid = 0, inst = 32'h0000_0013, inst_pc = 0
  - misalign = 0
- Reset mid-operation discards all queued entries and any pending redirect.
- Latency:
  - First inst_valid = 1 in the cycle after the first edge with rstn = 0.
  - Redirect sampled at edge N: inst_valid = 0 after edge N; target fetched at edge N+1; inst_valid = 1 after edge N+1.
- Throughput: one instruction per cycle while inst_ready is held at 1.
- Back-pressure: with inst_ready = 0, the queue fills to DEPTH and fpc freezes at head pc + 4·DEPTH.

## Configuration
- FETCH_MISALIGN_CHK_EN defined:
  - A redirect with redirect_pc[1:0] != 0 sets misalign and halted.
  - The queue flushes and fetch stops; inst_valid stays 0 until reset.
  - Later redirects are ignored.
- Undefined:
  - No misalign port and no halted bit.
  - fpc loads {redirect_pc[31:2], 2'b00}.

## Test plan
- Reset release with RESET_PC = 0, imem words 0..3 = 0x293, 0x313, 0xFFFFF3B7, 0x13, inst_ready = 1 → inst/inst_pc sequence (0x293, 0), (0x313, 4), (0xFFFFF3B7, 8), (0x13, 12), one per cycle.
- inst_ready = 0 for 5 cycles after reset → count = 2, inst = 0x293 held, fpc = 8; inst_ready = 1 → words 0, 1, 2 delivered back-to-back, no word lost or duplicated.
- Redirect to 0x174 while queue is full → next cycle inst_valid = 0; following cycle inst_pc = 0x174, inst = imem[93]; no stale entries delivered.
- Redirect asserted in the same cycle as a pop, and also during a push attempt → flush wins, count = 0, fpc = target.
- fpc at 0x3FC with IMEM_AW = 8 → next fetch address wraps to imem_addr 0, inst_pc = 0x400.
- With FETCH_MISALIGN_CHK_EN, redirect to 0x102 → misalign = 1, inst_valid stays 0 for 10 cycles, misalign clears only on rstn = 1; without the macro → inst_pc = 0x100.
